// File: rtl/draw_board_figures_if.sv
// vga_if: VGA pixel bundle (timing counters, syncs, blanking, 12-bit colour).
interface vga_if;
   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;
   modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_board_figures.sv
// draw_board_figures: overlays ROM chess glyphs and a blinking selection highlight on the 8x8 board.
module draw_board_figures #(
   parameter int          BOARD_X      = 256,
   parameter int          BOARD_Y      = 128,
   parameter int          TILE_SIZE    = 64,
   parameter int          SCALE_SHIFT  = 1,
   parameter int          GLYPH_W      = TILE_SIZE >> SCALE_SHIFT,
   parameter int          ROM_LATENCY  = 1,
   parameter logic [11:0] COLOR_1      = 12'h666,
   parameter logic [11:0] COLOR_2      = 12'hfff,
   parameter logic [11:0] COLOR_3      = 12'h000,
   parameter logic [11:0] HILITE_COLOR = 12'h0f0,
   parameter int          BLINK_FRAMES = 30
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2*GLYPH_W-1:0]       glyph_row,
   output logic [5:0]                 square_idx,
   output logic [$clog2(GLYPH_W)-1:0] glyph_line,
   input  logic                       sel_en,
   input  logic [5:0]                 sel_square,
   vga_if.in                          vga_in,
   vga_if.out                         vga_out
);
   localparam int TB = $clog2(TILE_SIZE);
   localparam int GW = $clog2(GLYPH_W);
   localparam int AW = TB + 3;
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [10:0] X0 = 11'(BOARD_X);
   localparam logic [10:0] X1 = 11'(BOARD_X + 8*TILE_SIZE);
   localparam logic [10:0] Y0 = 11'(BOARD_Y);
   localparam logic [10:0] Y1 = 11'(BOARD_Y + 8*TILE_SIZE);
   typedef struct packed {
      logic [10:0]   vcount;
      logic          vsync;
      logic          vblnk;
      logic [10:0]   hcount;
      logic          hsync;
      logic          hblnk;
      logic [11:0]   rgb;
      logic          in_board;
      logic [GW-1:0] gcol;
      logic          border;
      logic          fill;
   } stage_t;
   stage_t [ROM_LATENCY:0] pipe;
   stage_t s0;
   stage_t p;
   logic [AW-1:0] dx;
   logic [AW-1:0] dy;
   logic [TB-1:0] ox;
   logic [TB-1:0] oy;
   logic [5:0] sq;
   logic in_board;
   logic in_sel;
   logic [1:0] code;
   logic [FW-1:0] frame_cnt;
   logic blink_phase;
   logic vblnk_rise;
   logic [11:0] rgb_next;
   always_comb begin
      dx = AW'(vga_in.hcount - X0);
      dy = AW'(vga_in.vcount - Y0);
      ox = dx[TB-1:0];
      oy = dy[TB-1:0];
      sq = {dy[AW-1:TB], dx[AW-1:TB]};
      in_board = vga_in.hcount >= X0 && vga_in.hcount < X1 && vga_in.vcount >= Y0 && vga_in.vcount < Y1;
      in_sel = sel_en && sq == sel_square;
      s0 = '{vcount: vga_in.vcount, vsync: vga_in.vsync, vblnk: vga_in.vblnk,
             hcount: vga_in.hcount, hsync: vga_in.hsync, hblnk: vga_in.hblnk,
             rgb: vga_in.rgb, in_board: in_board, gcol: ox[TB-1:SCALE_SHIFT],
             border: in_sel && (ox < TB'(2) || ox >= TB'(TILE_SIZE-2) || oy < TB'(2) || oy >= TB'(TILE_SIZE-2)),
             fill: in_sel};
      vblnk_rise = vga_in.vblnk && !pipe[0].vblnk;
      p = pipe[ROM_LATENCY];
      // pixel 0 sits in the top bits of the ROM word
      code = 2'(glyph_row >> {GW'(GLYPH_W-1) - p.gcol, 1'b0});
      rgb_next = !p.in_board ? p.rgb :
                 p.border ? HILITE_COLOR :
                 code == 2'b00 ? (p.fill && blink_phase ? HILITE_COLOR : p.rgb) :
                 code == 2'b01 ? COLOR_1 :
                 code == 2'b10 ? COLOR_2 : COLOR_3;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe <= '0;
         square_idx <= '0;
         glyph_line <= '0;
         frame_cnt <= '0;
         blink_phase <= 1'b0;
         vga_out.vcount <= '0;
         vga_out.vsync <= 1'b0;
         vga_out.vblnk <= 1'b0;
         vga_out.hcount <= '0;
         vga_out.hsync <= 1'b0;
         vga_out.hblnk <= 1'b0;
         vga_out.rgb <= '0;
      end else begin
         pipe <= {pipe[ROM_LATENCY-1:0], s0};
         square_idx <= in_board ? sq : '0;
         glyph_line <= in_board ? oy[TB-1:SCALE_SHIFT] : '0;
         if (vblnk_rise) begin
            frame_cnt <= frame_cnt == FW'(BLINK_FRAMES-1) ? '0 : frame_cnt + 1'b1;
            blink_phase <= frame_cnt == FW'(BLINK_FRAMES-1) ? !blink_phase : blink_phase;
         end
         vga_out.vcount <= p.vcount;
         vga_out.vsync <= p.vsync;
         vga_out.vblnk <= p.vblnk;
         vga_out.hcount <= p.hcount;
         vga_out.hsync <= p.hsync;
         vga_out.hblnk <= p.hblnk;
         vga_out.rgb <= rgb_next;
      end
   end
endmodule

// File: tb/tb_draw_board_figures.sv
// tb_draw_board_figures: directed checks of two renderers (ROM latency 1 and 3) sharing one pixel stream.
module tb_draw_board_figures;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   vga_if vin();
   vga_if vo1();
   vga_if vo3();
   logic [63:0] test_word = '0;
   logic [63:0] rp1;
   logic [63:0] rp3 [3];
   logic [5:0] sq1, sq3;
   logic [4:0] gl1, gl3;
   logic sel_en = 1'b0;
   logic [5:0] sel_square = '0;
   logic [63:0] out1, out3;
   logic [63:0] r_o1, r_o3;
   logic [5:0] r_sq1, r_sq3;
   logic [4:0] r_gl1;
   int vectors = 0;
   int errors = 0;
   draw_board_figures #(.ROM_LATENCY(1), .BLINK_FRAMES(2)) u1 (
      .clk(clk), .rst(rst), .glyph_row(rp1), .square_idx(sq1), .glyph_line(gl1),
      .sel_en(sel_en), .sel_square(sel_square), .vga_in(vin), .vga_out(vo1));
   draw_board_figures #(.ROM_LATENCY(3), .BLINK_FRAMES(2)) u3 (
      .clk(clk), .rst(rst), .glyph_row(rp3[2]), .square_idx(sq3), .glyph_line(gl3),
      .sel_en(sel_en), .sel_square(sel_square), .vga_in(vin), .vga_out(vo3));
   assign out1 = {26'd0, vo1.hcount, vo1.vcount, vo1.hsync, vo1.vsync, vo1.hblnk, vo1.vblnk, vo1.rgb};
   assign out3 = {26'd0, vo3.hcount, vo3.vcount, vo3.hsync, vo3.vsync, vo3.hblnk, vo3.vblnk, vo3.rgb};
   // square 0: even glyph pixels transparent, odd ones code 01; square 43 line 3 is the test word; rest all code 11
   function automatic logic [63:0] rom_word(input logic [5:0] sq, input logic [4:0] gl);
      return sq == 6'd0 ? 64'h1111_1111_1111_1111 : (sq == 6'd43 && gl == 5'd3) ? test_word : '1;
   endfunction
   always @(posedge clk) begin
      rp1 <= rom_word(sq1, gl1);
      rp3[0] <= rom_word(sq3, gl3);
      rp3[1] <= rp3[0];
      rp3[2] <= rp3[1];
   end
   function automatic logic [63:0] pk(input logic [10:0] h, v, input logic [3:0] syn, input logic [11:0] c);
      return {26'd0, h, v, syn, c};
   endfunction
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [10:0] h, v, input logic [11:0] c, input logic [3:0] syn);
      vin.hcount = h;
      vin.vcount = v;
      vin.rgb = c;
      {vin.hsync, vin.vsync, vin.hblnk, vin.vblnk} = syn;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // one pixel for one cycle, then idle; outputs captured exactly 3 and 5 cycles later
   task automatic run_px(input logic [10:0] h, v, input logic [11:0] c, input logic [3:0] syn);
      drive(h, v, c, syn);
      tick(1);
      r_sq1 = sq1;
      r_gl1 = gl1;
      r_sq3 = sq3;
      drive(11'd0, 11'd0, 12'h000, 4'b0000);
      tick(2);
      r_o1 = out1;
      tick(2);
      r_o3 = out3;
   endtask
   task automatic pulse_vblnk();
      drive(11'd0, 11'd0, 12'h000, 4'b0001);
      tick(1);
      drive(11'd0, 11'd0, 12'h000, 4'b0000);
      tick(1);
   endtask
   initial begin
      drive(11'($urandom), 11'($urandom), 12'($urandom), 4'($urandom));
      tick(3);
      chk("rst_out_l3", out1, '0);
      chk("rst_out_l5", out3, '0);
      chk("rst_addr_l3", {58'd0, sq1}, {53'd0, 5'd0, 6'd0} | {59'd0, gl1});
      chk("rst_addr_l5", {53'd0, gl3, sq3}, '0);
      rst = 1'b0;
      run_px(11'd100, 11'd50, 12'h123, 4'b1010);
      chk("pass_l3", r_o1, pk(11'd100, 11'd50, 4'b1010, 12'h123));
      chk("pass_l5", r_o3, pk(11'd100, 11'd50, 4'b1010, 12'h123));
      chk("pass_sq", {58'd0, r_sq1}, 64'd0);
      run_px(11'd50, 11'd700, 12'h9c3, 4'b0101);
      chk("pass2_l3", r_o1, pk(11'd50, 11'd700, 4'b0101, 12'h9c3));
      chk("pass2_l5", r_o3, pk(11'd50, 11'd700, 4'b0101, 12'h9c3));
      test_word = 64'h0020_0000_0000_0000;
      run_px(11'd458, 11'd455, 12'h321, 4'b0000);
      chk("addr_sq_l3", {58'd0, r_sq1}, 64'd43);
      chk("addr_line", {59'd0, r_gl1}, 64'd3);
      chk("addr_sq_l5", {58'd0, r_sq3}, 64'd43);
      chk("dec10_l3", r_o1, pk(11'd458, 11'd455, 4'b0000, 12'hfff));
      chk("dec10_l5", r_o3, pk(11'd458, 11'd455, 4'b0000, 12'hfff));
      run_px(11'd456, 11'd455, 12'h321, 4'b0000);
      chk("dec_nbr_l3", {52'd0, r_o1[11:0]}, 64'h321);
      chk("dec_nbr_l5", {52'd0, r_o3[11:0]}, 64'h321);
      test_word = 64'h0010_0000_0000_0000;
      run_px(11'd458, 11'd455, 12'h321, 4'b0000);
      chk("dec01_l3", {52'd0, r_o1[11:0]}, 64'h666);
      chk("dec01_l5", {52'd0, r_o3[11:0]}, 64'h666);
      test_word = '0;
      run_px(11'd458, 11'd455, 12'h321, 4'b0000);
      chk("dec00_l3", {52'd0, r_o1[11:0]}, 64'h321);
      chk("dec00_l5", {52'd0, r_o3[11:0]}, 64'h321);
      run_px(11'd767, 11'd200, 12'h5a5, 4'b0000);
      chk("h767_sq", {58'd0, r_sq1}, 64'd15);
      chk("h767_rgb", {52'd0, r_o1[11:0]}, 64'h000);
      run_px(11'd768, 11'd200, 12'h5a5, 4'b0000);
      chk("h768_sq", {58'd0, r_sq1}, 64'd0);
      chk("h768_rgb", {52'd0, r_o3[11:0]}, 64'h5a5);
      run_px(11'd300, 11'd639, 12'h5a5, 4'b0000);
      chk("v639_sq", {58'd0, r_sq3}, 64'd56);
      chk("v639_rgb", {52'd0, r_o1[11:0]}, 64'h000);
      run_px(11'd300, 11'd640, 12'h5a5, 4'b0000);
      chk("v640_rgb", {52'd0, r_o1[11:0]}, 64'h5a5);
      run_px(11'd255, 11'd200, 12'h5a5, 4'b0000);
      chk("h255_rgb", {52'd0, r_o1[11:0]}, 64'h5a5);
      run_px(11'd300, 11'd127, 12'h5a5, 4'b0000);
      chk("v127_rgb", {52'd0, r_o3[11:0]}, 64'h5a5);
      drive(11'd319, 11'd136, 12'h5a5, 4'b0000);
      tick(1);
      chk("seam_sq319", {58'd0, sq1}, 64'd0);
      drive(11'd320, 11'd136, 12'h5a5, 4'b0000);
      tick(1);
      chk("seam_sq320", {58'd0, sq1}, 64'd1);
      drive(11'd0, 11'd0, 12'h000, 4'b0000);
      tick(1);
      chk("seam319_l3", out1, pk(11'd319, 11'd136, 4'b0000, 12'h666));
      tick(1);
      chk("seam320_l3", out1, pk(11'd320, 11'd136, 4'b0000, 12'h000));
      tick(1);
      chk("seam319_l5", out3, pk(11'd319, 11'd136, 4'b0000, 12'h666));
      tick(1);
      chk("seam320_l5", out3, pk(11'd320, 11'd136, 4'b0000, 12'h000));
      test_word = 64'h0020_0000_0000_0000;
      drive(11'd458, 11'd455, 12'h321, 4'b0000);
      tick(1);
      rst = 1'b1;
      tick(1);
      chk("midrst_l5", out3, '0);
      rst = 1'b0;
      drive(11'd100, 11'd50, 12'h7e7, 4'b1000);
      tick(1);
      drive(11'd0, 11'd0, 12'h000, 4'b0000);
      tick(2);
      chk("resume_l3", out1, pk(11'd100, 11'd50, 4'b1000, 12'h7e7));
      tick(1);
      chk("flush_l5", out3, '0);
      tick(1);
      chk("resume_l5", out3, pk(11'd100, 11'd50, 4'b1000, 12'h7e7));
      sel_en = 1'b1;
      sel_square = 6'd0;
      run_px(11'd256, 11'd128, 12'h246, 4'b0000);
      chk("hl_corner_l3", {52'd0, r_o1[11:0]}, 64'h0f0);
      chk("hl_corner_l5", {52'd0, r_o3[11:0]}, 64'h0f0);
      run_px(11'd258, 11'd128, 12'h246, 4'b0000);
      chk("hl_over_glyph", {52'd0, r_o1[11:0]}, 64'h0f0);
      run_px(11'd318, 11'd138, 12'h246, 4'b0000);
      chk("hl_right2", {52'd0, r_o1[11:0]}, 64'h0f0);
      run_px(11'd317, 11'd138, 12'h246, 4'b0000);
      chk("hl_right3", {52'd0, r_o1[11:0]}, 64'h246);
      run_px(11'd264, 11'd138, 12'h246, 4'b0000);
      chk("blink0_l3", {52'd0, r_o1[11:0]}, 64'h246);
      run_px(11'd266, 11'd138, 12'h246, 4'b0000);
      chk("opaque_ph0", {52'd0, r_o1[11:0]}, 64'h666);
      pulse_vblnk();
      run_px(11'd264, 11'd138, 12'h246, 4'b0000);
      chk("blink_1rise", {52'd0, r_o1[11:0]}, 64'h246);
      pulse_vblnk();
      run_px(11'd264, 11'd138, 12'h246, 4'b0000);
      chk("blink1_l3", {52'd0, r_o1[11:0]}, 64'h0f0);
      chk("blink1_l5", {52'd0, r_o3[11:0]}, 64'h0f0);
      run_px(11'd266, 11'd138, 12'h246, 4'b0000);
      chk("opaque_ph1", {52'd0, r_o3[11:0]}, 64'h666);
      sel_en = 1'b0;
      run_px(11'd264, 11'd138, 12'h246, 4'b0000);
      chk("seloff_fill", {52'd0, r_o1[11:0]}, 64'h246);
      run_px(11'd258, 11'd128, 12'h246, 4'b0000);
      chk("seloff_border", {52'd0, r_o1[11:0]}, 64'h666);
      sel_en = 1'b1;
      sel_square = 6'd1;
      run_px(11'd264, 11'd138, 12'h246, 4'b0000);
      chk("othersq_fill", {52'd0, r_o1[11:0]}, 64'h246);
      sel_square = 6'd0;
      pulse_vblnk();
      run_px(11'd264, 11'd138, 12'h246, 4'b0000);
      chk("blink_3rise", {52'd0, r_o1[11:0]}, 64'h0f0);
      pulse_vblnk();
      run_px(11'd264, 11'd138, 12'h246, 4'b0000);
      chk("blink_4rise", {52'd0, r_o1[11:0]}, 64'h246);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/draw_board_figures.md
# draw_board_figures

Parametrised chess-piece renderer for the full 8x8 board. It sits in the VGA pipeline after the board-square painter. For every pixel inside the board it requests one glyph row from the figure ROM and decodes the 2-bit-per-pixel code through a palette. It also overlays a selected-square highlight whose fill blinks on a frame-based timer. Sync and blanking signals are delayed to stay aligned with the RGB they accompany.

## Interface
Parameters:
- BOARD_X, 256, hcount of the board's left edge.
- BOARD_Y, 128, vcount of the board's top edge.
- TILE_SIZE, 64, square edge in screen pixels; must be a power of two.
- SCALE_SHIFT, 1, each glyph pixel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels.
- GLYPH_W, TILE_SIZE>>SCALE_SHIFT, glyph pixels per row (derived; do not override).
- ROM_LATENCY, 1, cycles from address out to glyph_row valid; legal values 1..3.
- COLOR_1 / COLOR_2 / COLOR_3, 12'h666 / 12'hfff / 12'h000, palette for codes 01 / 10 / 11.
- HILITE_COLOR, 12'h0f0, colour of the selection border and blink fill.
- BLINK_FRAMES, 30, frames per blink half-period.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; synchronous, active-high.
- glyph_row  in  2*GLYPH_W  ROM data. Pixel 0 is at bits [2*GLYPH_W-1 -: 2].
- square_idx  out  6  {row[2:0], col[2:0]} of the requested square.
- glyph_line  out  $clog2(GLYPH_W)  glyph row requested.
- sel_en  in  1  highlight enable.
- sel_square  in  6  {row, col} of the selected square.
- vga_in  vga_if.in  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb[11:0].
- vga_out  vga_if.out  same fields, delayed.

## Operation
- Board region: hcount in [BOARD_X, BOARD_X+8*TILE_SIZE) and vcount in [BOARD_Y, BOARD_Y+8*TILE_SIZE). Both bounds are half-open.
- Offsets: dx = hcount−BOARD_X, dy = vcount−BOARD_Y, both computed at 11 bits.
- Square: col = dx/TILE_SIZE, row = dy/TILE_SIZE.
- Glyph row: glyph_line = (dy mod TILE_SIZE)>>SCALE_SHIFT.
- Glyph column: gcol = (dx mod TILE_SIZE)>>SCALE_SHIFT.
- Outside the board, square_idx and glyph_line are driven 0.
- Pixel code: code = glyph_row[2*(GLYPH_W−1−gcol) +: 2], using the gcol carried down the pipeline.
- Pixel decode: 00 is transparent, 01 is COLOR_1, 10 is COLOR_2, 11 is COLOR_3.
- Output priority, highest first:
  1. Outside the board: pass vga_in.rgb through.
  2. sel_en, pixel in sel_square, and within 2 screen pixels of that square's edge: HILITE_COLOR.
  3. Code 00, sel_en, pixel in sel_square, and blink_phase=1: HILITE_COLOR.
  4. Code 00: pass rgb through.
  5. Otherwise: palette colour.
- Blink timer:
  - frame_cnt counts rising edges of vga_in.vblnk (0→1 across consecutive cycles).
  - On reaching BLINK_FRAMES−1 it wraps to 0 and toggles blink_phase.
- sel_en and sel_square are sampled in the same pipeline stage as the address. Changing them mid-frame affects only pixels entering after the change.

## Timing
- Let L = ROM_LATENCY+2.
- Stage 0: vga_in is registered. square_idx and glyph_line are registered outputs, valid 1 cycle after the pixel enters.
- ROM: glyph_row is sampled ROM_LATENCY cycles after square_idx/glyph_line change.
- Output: the output register updates at the next edge.
- Total latency: every vga_out field equals the corresponding vga_in field delayed by exactly L cycles. rgb is modified as described in Operation.
- The in-board flag, gcol, highlight flags and rgb travel in the same delay line, so no misalignment is allowed at tile or board boundaries.
- The blink phase is applied at the output stage. A toggle takes effect on the next pixel to reach the output; mid-frame tearing is accepted.
- Reset: all vga_out fields, square_idx, glyph_line, frame_cnt, blink_phase and all pipeline registers are 0 on the cycle after rst is sampled high.
- Reset asserted mid-frame: the pipeline flushes to zeros. Valid output resumes L cycles after rst falls.
- Wrap and corners:
  - The last pixel (hcount=BOARD_X+8*TILE_SIZE−1) is in the board. The next pixel is passed through.
  - dx or dy underflow outside the board is don't-care because the in-board flag gates it.

## Test plan
- **Reset:** hold rst 3 cycles with random vga_in → every output is 0. After release, vga_out.hcount equals the hcount applied L=3 cycles earlier.
- **Pass-through and latency:** pixel (100,50) with rgb 12'h123 → vga_out.rgb=12'h123 after 3 cycles; hsync, vsync, hblnk and vblnk are delayed identically; square_idx=0.
- **Address and decode:**
  - Pixel (hcount=256+64*3+10, vcount=128+64*5+7) → square_idx=6'b101_011, glyph_line=3, gcol=5.
  - Glyph_row with pixel 5 = 10 → rgb 12'hfff.
  - With pixel 5 = 00 → input rgb.
- **Boundaries:** hcount 767 is in the board, 768 is not; vcount 639 is in the board, 640 is not. Tile seams at 319/320 give col 0→1 with no one-cycle glitch.
- **Highlight and blink (BLINK_FRAMES=2 in bench):**
  - sel_en=1, sel_square=0: pixel (256,128) → HILITE_COLOR.
  - A transparent interior pixel → HILITE_COLOR only while blink_phase=1; the phase toggles every 2 vblnk rising edges.
  - A non-transparent interior pixel keeps its palette colour.
- **ROM_LATENCY=3 variant:** bench ROM model delays data 3 cycles → decode is correct and latency is 5. Rst asserted mid-line flushes the pipeline, and the first valid pixel appears 5 cycles after rst falls.
